// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit, the control unit and benches.
package instr_fetch_unit_pkg;

    localparam int          DEFAULT_XLEN     = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Major opcodes seen by the control unit on the opcode output.
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} pairs between imem and decode.
// Flush wins over push and pop; the head entry is presented combinationally.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;

    assign full      = (count == CNT_W'(DEPTH));
    assign head_data = mem[rd_ptr];

    // Pointer, occupancy and storage update; storage is cleared on reset so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // The issue credit in the parent must never let a response land in a full buffer.
    assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word reads to a one-cycle imem,
// buffers returned words and hands them to decode over valid/ready.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          XLEN       = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    req_pc;
    logic               inflight;
    logic               inflight_killed;
    logic               pop;
    logic               push;
    logic [CNT_W-1:0]   count;
    logic [OCC_W-1:0]   occupancy;
    logic [XLEN+31:0]   head_data;

    assign pop       = instr_valid & instr_ready;
    assign push      = inflight & ~inflight_killed;

    // Occupancy counts buffered words plus the one in flight, minus the one leaving now.
    assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
    assign imem_req  = ~rst & ~redirect & (occupancy < OCC_W'(FIFO_DEPTH));
    assign imem_addr = fetch_pc;

    assign instr_valid        = (count != '0);
    assign {instr_pc, instr}  = head_data;
    assign opcode             = instr[6:0];

    // PC advance, in-flight tracking and redirect handling; redirect targets are forced word aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc        <= RESET_PC;
            req_pc          <= '0;
            inflight        <= 1'b0;
            inflight_killed <= 1'b0;
        end else begin
            inflight        <= imem_req;
            inflight_killed <= redirect;
            if (redirect) begin
                fetch_pc <= redirect_pc & ~XLEN'(3);
            end else if (imem_req) begin
                fetch_pc <= fetch_pc + XLEN'(4);
                req_pc   <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN + 32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data ({req_pc, imem_rdata}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, streaming, backpressure,
// mid-stream reset, redirects (aligned, misaligned, back-to-back) and PC wrap.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic        w_instr_valid;
    logic        w_instr_ready;
    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [31:0] w_instr_pc;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;

    int n_checks;
    int n_fail;

    instr_fetch_unit u_dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .opcode      (opcode),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (w_imem_req),
        .imem_addr   (w_imem_addr),
        .imem_rdata  (w_imem_rdata),
        .instr_valid (w_instr_valid),
        .instr_ready (w_instr_ready),
        .instr       (w_instr),
        .opcode      (w_opcode),
        .instr_pc    (w_instr_pc),
        .redirect    (w_redirect),
        .redirect_pc (w_redirect_pc)
    );

    // Instruction memory contents: four known words at 0..12, an address-derived pattern elsewhere.
    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00B5_0533;
            32'h4:   return 32'h0005_A583;
            32'h8:   return 32'h00B5_2023;
            32'hC:   return 32'h00B5_0463;
            default: return a ^ 32'h5A00_0013;
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous imem models: data returned the cycle after a request.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= memf(imem_addr);
        if (w_imem_req) w_imem_rdata <= memf(w_imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, drive inputs just after the edge, then let outputs settle.
    task automatic tick(input logic rdy, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
    endtask

    // Hold reset for two edges, check reset outputs, release; returns in cycle 0.
    task automatic do_reset();
        rst         = 1'b1;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_req",   32'(imem_req),    32'd0);
        check("rst_instr", instr,            32'h0);
        check("rst_pc",    instr_pc,         32'h0);
        check("rst_op",    32'(opcode),      32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        imem_rdata    = '0;
        w_imem_rdata  = '0;
        w_instr_ready = 1'b1;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;

        // Streaming after reset, plus wrap instance.
        do_reset();
        check("c0_req",  32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        check("c0_valid", 32'(instr_valid), 32'd0);
        check("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
        tick(1'b1, 1'b0, '0);
        check("c1_addr", imem_addr, 32'h4);
        check("c1_valid", 32'(instr_valid), 32'd0);
        check("wrap_addr1", w_imem_addr, 32'h0);
        tick(1'b1, 1'b0, '0);
        check("c2_valid", 32'(instr_valid), 32'd1);
        check("c2_instr", instr, 32'h00B5_0533);
        check("c2_op",    32'(opcode), 32'(OP_R));
        check("c2_pc",    instr_pc, 32'h0);
        check("c2_addr",  imem_addr, 32'h8);
        check("wrap_pc",  w_instr_pc, 32'hFFFF_FFFC);
        tick(1'b1, 1'b0, '0);
        check("c3_instr", instr, 32'h0005_A583);
        check("c3_op",    32'(opcode), 32'(OP_LOAD));
        check("c3_pc",    instr_pc, 32'h4);
        tick(1'b1, 1'b0, '0);
        check("c4_op",    32'(opcode), 32'(OP_STORE));
        check("c4_pc",    instr_pc, 32'h8);
        tick(1'b1, 1'b0, '0);
        check("c5_instr", instr, 32'h00B5_0463);
        check("c5_op",    32'(opcode), 32'(OP_BRANCH));
        check("c5_pc",    instr_pc, 32'hC);

        // Backpressure: buffer fills to two, requests stop, nothing lost on release.
        do_reset();
        tick(1'b1, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        check("bp_c2_req", 32'(imem_req), 32'd0);
        tick(1'b0, 1'b0, '0);
        check("bp_c3_req", 32'(imem_req), 32'd0);
        check("bp_c3_instr", instr, 32'h00B5_0533);
        tick(1'b0, 1'b0, '0);
        check("bp_c4_req", 32'(imem_req), 32'd0);
        check("bp_c4_valid", 32'(instr_valid), 32'd1);
        check("bp_c4_instr", instr, 32'h00B5_0533);
        tick(1'b1, 1'b0, '0);
        check("bp_c5_pc", instr_pc, 32'h0);
        check("bp_c5_addr", imem_addr, 32'h8);
        check("bp_c5_req", 32'(imem_req), 32'd1);
        tick(1'b1, 1'b0, '0);
        check("bp_c6_pc", instr_pc, 32'h4);
        check("bp_c6_addr", imem_addr, 32'hC);
        tick(1'b1, 1'b0, '0);
        check("bp_c7_pc", instr_pc, 32'h8);
        check("bp_c7_valid", 32'(instr_valid), 32'd1);
        tick(1'b1, 1'b0, '0);
        check("bp_c8_pc", instr_pc, 32'hC);

        // Reset while the buffer is full.
        do_reset();
        tick(1'b1, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        check("mr_full_valid", 32'(instr_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mr_valid", 32'(instr_valid), 32'd0);
        check("mr_req",   32'(imem_req), 32'd0);
        check("mr_instr", instr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("mr_c0_addr", imem_addr, 32'h0);
        check("mr_c0_req",  32'(imem_req), 32'd1);
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        check("mr_c2_pc", instr_pc, 32'h0);
        check("mr_c2_valid", 32'(instr_valid), 32'd1);

        // Redirect with the fetch of 0x8 in flight.
        do_reset();
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        check("rd_c2_addr", imem_addr, 32'h8);
        tick(1'b1, 1'b1, 32'h40);
        check("rd_R_req", 32'(imem_req), 32'd0);
        check("rd_R_pc",  instr_pc, 32'h4);
        tick(1'b1, 1'b0, '0);
        check("rd_R1_valid", 32'(instr_valid), 32'd0);
        check("rd_R1_addr",  imem_addr, 32'h40);
        check("rd_R1_req",   32'(imem_req), 32'd1);
        tick(1'b1, 1'b0, '0);
        check("rd_R2_valid", 32'(instr_valid), 32'd0);
        check("rd_R2_addr",  imem_addr, 32'h44);
        tick(1'b1, 1'b0, '0);
        check("rd_R3_valid", 32'(instr_valid), 32'd1);
        check("rd_R3_pc",    instr_pc, 32'h40);
        check("rd_R3_instr", instr, memf(32'h40));
        tick(1'b1, 1'b0, '0);
        check("rd_R4_pc", instr_pc, 32'h44);

        // Misaligned redirect target is word aligned.
        tick(1'b1, 1'b1, 32'h4E);
        tick(1'b1, 1'b0, '0);
        check("mis_addr",  imem_addr, 32'h4C);
        check("mis_valid", 32'(instr_valid), 32'd0);
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        check("mis_pc", instr_pc, 32'h4C);

        // Back-to-back redirects: the last target wins.
        tick(1'b1, 1'b1, 32'h100);
        tick(1'b1, 1'b1, 32'h200);
        check("bb_valid", 32'(instr_valid), 32'd0);
        check("bb_req",   32'(imem_req), 32'd0);
        tick(1'b1, 1'b0, '0);
        check("bb_addr",  imem_addr, 32'h200);
        tick(1'b1, 1'b0, '0);
        check("bb_addr2", imem_addr, 32'h204);
        check("bb_valid2", 32'(instr_valid), 32'd0);
        tick(1'b1, 1'b0, '0);
        check("bb_pc", instr_pc, 32'h200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
